wb_ram_arbiter: RTL

//  Shares one single-port Wishbone RAM slave (8-bit addr/data, combinational ack,

---
 rtl/wb_ram_arbiter_pkg.sv | 23 ++
 rtl/wb_ram_arbiter_rr_picker.sv | 31 +++
 rtl/wb_ram_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/wb_ram_arbiter_pkg.sv
// Shared FSM encoding and width helper for the Wishbone RAM arbiter.
package wb_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RWAIT  = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  // Wide enough for READ_LATENCY values up to 3.
  localparam int LAT_W = 2;

  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_ram_arbiter_rr_picker.sv
// Combinational round-robin select: first requester strictly after last_i,
// wrapping modulo NUM_MASTERS. Holds no state.
module rr_picker
  import wb_ram_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int GW          = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [GW-1:0]          last_i,
  output logic                   valid_o,
  output logic [GW-1:0]          index_o
);

  logic [GW:0] pos;

  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    pos     = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      pos = {1'b0, last_i} + (GW+1)'(k);
      if (pos >= (GW+1)'(NUM_MASTERS)) pos = pos - (GW+1)'(NUM_MASTERS);
      if (!valid_o && req_i[pos[GW-1:0]]) begin
        valid_o = 1'b1;
        index_o = pos[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin arbiter sharing one single-port Wishbone RAM between NUM_MASTERS
// requesters; one transfer per grant, read latency hidden behind the master ack.
//
//  state     | meaning
//  ST_IDLE   | no transfer; sample m_stb_i and pick next master
//  ST_ACCESS | strobe RAM with latched addr/data/we until s_ack_i
//  ST_RWAIT  | count down read latency, capture s_dat_i on last cycle
//  ST_ACK    | one-cycle ack to granted master, advance last grant
module wb_ram_arbiter
  import wb_ram_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS  = 4,
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int READ_LATENCY = 1,
  localparam int GW          = clog2_min1(NUM_MASTERS)
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  input  logic [NUM_MASTERS*AW-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [DW-1:0]             m_dat_o,
  output logic [AW-1:0]             s_addr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic                      s_we_o,
  output logic                      s_stb_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  output logic [GW-1:0]             grant_o,
  output logic                      busy_o
);

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic            we_q, we_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic            abort_q, abort_d;

  logic            pick_valid;
  logic [GW-1:0]   pick_idx;

  rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .GW         (GW)
  ) u_picker (
    .req_i  (m_stb_i),
    .last_i (last_q),
    .valid_o(pick_valid),
    .index_o(pick_idx)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_MASTERS - 1);
      addr_q  <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdat_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    rdat_d   = rdat_q;
    abort_d  = abort_q;
    s_stb_o  = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    m_ack_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          addr_d  = m_addr_i[int'(pick_idx)*AW +: AW];
          wdat_d  = m_dat_i[int'(pick_idx)*DW +: DW];
          we_d    = m_we_i[pick_idx];
          abort_d = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        s_stb_o  = 1'b1;
        s_addr_o = addr_q;
        s_dat_o  = wdat_q;
        s_we_o   = we_q;
        if (!m_stb_i[grant_q]) abort_d = 1'b1;
        if (s_ack_i) begin
          if (we_q) begin
            state_d = ST_ACK;
          end else begin
            cnt_d   = LAT_W'(READ_LATENCY);
            state_d = ST_RWAIT;
          end
        end
      end
      ST_RWAIT: begin
        if (!m_stb_i[grant_q]) abort_d = 1'b1;
        if (cnt_q == LAT_W'(1)) begin
          rdat_d  = s_dat_i;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        // A master that let go of stb mid-transfer gets no ack, but still
        // counts as served for fairness.
        m_ack_o[grant_q] = m_stb_i[grant_q] & ~abort_q;
        last_d           = grant_q;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_dat_o = rdat_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule
